// File: rtl/seq_cmp16_ctrl_pkg.sv
// Shared types and constants for the sequential nibble-serial magnitude comparator.
package seq_cmp16_ctrl_pkg;

  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sign-bit position for an operand of the given width.
  function automatic int unsigned sign_bit_pos(input int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/seq_cmp16_ctrl_comp4.sv
// 4-bit unsigned magnitude comparator slice, purely combinational.
module seq_cmp16_ctrl_comp4
  import seq_cmp16_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic                lt_c,
  output logic                eq_c,
  output logic                gt_c
);

  assign lt_c = (a < b);
  assign eq_c = (a == b);
  assign gt_c = (a > b);

endmodule

// File: rtl/seq_cmp16_ctrl.sv
// Nibble-serial magnitude comparison controller: one comp4 slice stepped MSB nibble
// first, early exit on first difference, signed order via sign-bit inversion.
module seq_cmp16_ctrl
  import seq_cmp16_ctrl_pkg::*;
#(
  parameter  int unsigned WIDTH   = DEF_WIDTH,
  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned SIGN_BIT = sign_bit_pos(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               lt_d, eq_d, gt_d;
  logic               busy_d, done_d;

  logic [NIBBLE_W-1:0] nib_a_c, nib_b_c;
  logic                slice_lt_c, slice_eq_c, slice_gt_c;

  // Nibble select feeding the shared slice.
  always_comb begin
    nib_a_c = '0;
    nib_b_c = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a_c = a_q[i*NIBBLE_W +: NIBBLE_W];
        nib_b_c = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  seq_cmp16_ctrl_comp4 u_comp4 (
    .a    (nib_a_c),
    .b    (nib_b_c),
    .lt_c (slice_lt_c),
    .eq_c (slice_eq_c),
    .gt_c (slice_gt_c)
  );

  // Next-state, operand latch and flag logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    lt_d    = lt;
    eq_d    = eq;
    gt_d    = gt;

    if (abort) begin
      state_d = IDLE;
      lt_d    = 1'b0;
      eq_d    = 1'b0;
      gt_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            // Flipping both sign bits maps two's-complement order onto unsigned order.
            a_d           = a;
            b_d           = b;
            a_d[SIGN_BIT] = a[SIGN_BIT] ^ signed_mode;
            b_d[SIGN_BIT] = b[SIGN_BIT] ^ signed_mode;
            idx_d         = IDX_MAX;
            lt_d          = 1'b0;
            eq_d          = 1'b0;
            gt_d          = 1'b0;
            state_d       = CMP;
          end else if (state_q == DONE) begin
            state_d = IDLE;
          end
        end
        CMP: begin
          if (!slice_eq_c) begin
            lt_d    = slice_lt_c;
            gt_d    = slice_gt_c;
            eq_d    = 1'b0;
            state_d = DONE;
          end else if (idx_q == '0) begin
            eq_d    = 1'b1;
            state_d = DONE;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == CMP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= IDX_MAX;
      a_q     <= '0;
      b_q     <= '0;
      lt      <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lt      <= lt_d;
      eq      <= eq_d;
      gt      <= gt_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: doc/seq_cmp16_ctrl.md
Name: seq_cmp16_ctrl

Overview:
- Sequential magnitude-comparison controller for the ALU16 flag path.
- Latches two 16-bit operands on a start handshake and steps a single 4-bit comparator slice across the operand nibbles, MSB nibble first.
- Terminates early on the first unequal nibble.
- Supports unsigned and two's-complement signed ordering; presents registered lt/eq/gt flags with a one-cycle done pulse.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4.
NIBBLES, WIDTH/4, number of compare steps (derived; do not override).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  request; accepted only in IDLE or DONE.
signed_mode  in  1  sampled with start; 1 = two's-complement ordering.
abort  in  1  synchronous cancel; returns to IDLE with no done pulse.
a  in  WIDTH  operand A, sampled on accepted start.
b  in  WIDTH  operand B, sampled on accepted start.
busy  out  1  high while in CMP.
done  out  1  one-cycle pulse when flags become valid.
lt  out  1  A < B (registered).
eq  out  1  A == B (registered).
gt  out  1  A > B (registered).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, lt=0, eq=0, gt=0, idx=NIBBLES-1, operand registers 0.
- States: IDLE, CMP, DONE.
- IDLE/DONE with start=1:
  - Latch a, b and signed_mode.
  - In signed mode, invert bit WIDTH-1 of both latched operands. This maps signed order onto unsigned order.
  - Set idx=NIBBLES-1, clear lt/eq/gt, go to CMP.
- DONE with start=0: go to IDLE. done is high only while in DONE.
- CMP, each cycle:
  - Drive the comparator slice with nibble idx of both latched operands.
  - If the slice reports not-equal: register lt/gt from the slice, eq=0, go to DONE.
  - Else if idx==0: register eq=1, go to DONE.
  - Else: idx-1, stay in CMP.
- start while in CMP is ignored; operands and mode do not change.
- Latency, counted from the edge that accepts start:
  - First-nibble mismatch: done high after 2 edges.
  - Full equality: done high after NIBBLES+1 edges (5 for WIDTH=16).
  - Mismatch at nibble k (MSB nibble = NIBBLES-1): done high after NIBBLES-k+1 edges.
- Flags hold their value after DONE until the next accepted start. Exactly one of lt/eq/gt is 1 once a result has been produced.
- Back-to-back: start in the DONE cycle is accepted. done pulses for one cycle and the next compare begins with no IDLE bubble.
- abort:
  - Takes effect at the next edge from any state: go to IDLE, clear lt/eq/gt, no done.
  - abort has priority over start and over compare completion in the same cycle.
- rst_n low mid-operation: immediate return to the reset values. No done is emitted for the interrupted operation.
- idx never wraps; it is only decremented in CMP when idx>0.

Decomposition:
- Shared package:
  - State encoding enum (IDLE=2'd0, CMP=2'd1, DONE=2'd2).
  - NIBBLE_W=4.
  - Helper constant for the sign-bit position (WIDTH-1).
- One sub-module: the existing 4-bit comparator slice comp4, instantiated once and time-multiplexed across nibbles. The controller adds no other comparison logic.
- The nibble select is a combinational mux indexed by idx.

Test Plan:
1. a=16'h1234, b=16'h1234, signed_mode=0, start for 1 cycle -> busy for 4 cycles; done pulses 5 edges after the start edge; eq=1, lt=0, gt=0.
2. a=16'h8000, b=16'h7FFF, signed_mode=0 -> done 2 edges after start, gt=1. Same operands with signed_mode=1 -> done 2 edges after start, lt=1.
3. a=16'h1235, b=16'h1234, unsigned -> full 4 compare cycles, gt=1. Then a=16'h0000, b=16'hFFFF with signed_mode=1 (0 vs -1) -> gt=1.
4. Start with a=16'h00F0, b=16'h0100; pulse start again with a=16'hFFFF during CMP -> second start ignored; lt=1, a single done pulse. Then start asserted in the DONE cycle -> new compare begins immediately.
5. Start a=16'h1234, b=16'h1234; assert abort in the 2nd CMP cycle -> IDLE next edge, no done, flags 0. Repeat with rst_n low mid-CMP -> outputs reset asynchronously, no done after release.
6. abort and start asserted in the same IDLE cycle -> remains IDLE, busy=0. Randomised unsigned/signed pairs checked against a reference compare, including the ±32767/−32768 extremes.
